// File: rtl/if_fetch_queue.sv
// if_fetch_queue: in-order {pc, instruction} prefetch buffer between fetch and decode.
// Ports: clk, rst (sync, active-high), flush, in_valid/in_pc/in_instruction/in_ready,
//        out_valid/out_pc/out_instruction/out_ready, count (occupancy 0..DEPTH).
// Optional FETCHQ_STATS_EN adds stat_flushed, stat_full_cycles, stat_pops (32-bit, saturating).
module if_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]          in_instruction,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_pc,
    output logic [DATA_W-1:0]          out_instruction,
    input  logic                       out_ready,
`ifdef FETCHQ_STATS_EN
    output logic [31:0]                stat_flushed,
    output logic [31:0]                stat_full_cycles,
    output logic [31:0]                stat_pops,
`endif
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] pc_mem  [DEPTH];
    logic [DATA_W-1:0] ins_mem [DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;

    // in_ready depends only on the occupancy register, never on out_ready.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Empty queue presents a NOP (all zeros) rather than stale storage.
    assign out_pc          = out_valid ? pc_mem[rd_ptr_q]  : '0;
    assign out_instruction = out_valid ? ins_mem[rd_ptr_q] : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the occupancy count alone decides validity.
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            pc_mem[wr_ptr_q]  <= in_pc;
            ins_mem[wr_ptr_q] <= in_instruction;
        end
    end

`ifdef FETCHQ_STATS_EN
    logic [31:0] flushed_q, full_q, pops_q;
    logic [32:0] flushed_sum;

    assign flushed_sum      = {1'b0, flushed_q} + 33'(count_q);
    assign stat_flushed     = flushed_q;
    assign stat_full_cycles = full_q;
    assign stat_pops        = pops_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            flushed_q <= '0;
            full_q    <= '0;
            pops_q    <= '0;
        end else begin
            if (flush)
                flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
            if (!in_ready && full_q != '1)
                full_q <= full_q + 32'd1;
            // A pop coinciding with flush is discarded and not counted.
            if (pop && !flush && pops_q != '1)
                pops_q <= pops_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed self-checking bench for if_fetch_queue (DEPTH=4, DATA_W=32).
// Covers reset, ordering, backpressure, full+pop, streaming wrap, flush and mid-run reset.
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instruction;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        out_ready;
    logic [2:0]  count;
`ifdef FETCHQ_STATS_EN
    logic [31:0] stat_flushed;
    logic [31:0] stat_full_cycles;
    logic [31:0] stat_pops;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(4), .DATA_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_instruction  (in_instruction),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instruction (out_instruction),
        .out_ready       (out_ready),
`ifdef FETCHQ_STATS_EN
        .stat_flushed    (stat_flushed),
        .stat_full_cycles(stat_full_cycles),
        .stat_pops       (stat_pops),
`endif
        .count           (count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc);
        in_valid       = v;
        in_pc          = pc;
        in_instruction = 32'hA000_0000 | pc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'd0);
        step();
        step();
        rst = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instruction, 32'd0);

        // Basic order
        set_in(1'b1, 32'd4);
        step();
        check("lat_out_pc", out_pc, 32'd4);
        check("lat_count", 32'(count), 32'd1);
        set_in(1'b1, 32'd8);  step();
        set_in(1'b1, 32'd12); step();
        set_in(1'b0, 32'd0);
        check("basic_count3", 32'(count), 32'd3);
        check("basic_head", out_pc, 32'd4);
        check("basic_instr", out_instruction, 32'hA000_0004);
        out_ready = 1'b1;
        step();
        check("basic_pc8", out_pc, 32'd8);
        check("basic_count2", 32'(count), 32'd2);
        step();
        check("basic_pc12", out_pc, 32'd12);
        check("basic_count1", 32'(count), 32'd1);
        step();
        check("basic_count0", 32'(count), 32'd0);
        check("basic_empty_valid", 32'(out_valid), 32'd0);
        check("basic_empty_instr", out_instruction, 32'd0);
        out_ready = 1'b0;

        // Fill and backpressure
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 32'(in_ready), 32'd1);
            set_in(1'b1, 32'd20 + 32'(4 * i));
            step();
        end
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(count), 32'd4);
        check("fill_head", out_pc, 32'd20);
        set_in(1'b1, 32'd36);
        step();
        check("hold_count", 32'(count), 32'd4);
        check("hold_head", out_pc, 32'd20);

        // Full with simultaneous pop
        out_ready = 1'b1;
        step();
        check("fullpop_count", 32'(count), 32'd3);
        check("fullpop_in_ready", 32'(in_ready), 32'd1);
        check("fullpop_head", out_pc, 32'd24);
        out_ready = 1'b0;
        step();
        check("accept_count", 32'(count), 32'd4);
        set_in(1'b0, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", out_pc, 32'd24 + 32'(4 * i));
            step();
        end
        check("drain_count", 32'(count), 32'd0);

        // Streaming wrap (out_ready stays high)
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 32'd100 + 32'(4 * i));
            step();
            check("stream_pc", out_pc, 32'd100 + 32'(4 * i));
            check("stream_count", 32'(count), 32'd1);
        end
        set_in(1'b0, 32'd0);
        step();
        check("stream_end_count", 32'(count), 32'd0);
        out_ready = 1'b0;

        // Flush with push and pop requested
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'd300 + 32'(4 * i));
            step();
        end
        check("preflush_count", 32'(count), 32'd3);
        flush = 1'b1; out_ready = 1'b1;
        set_in(1'b1, 32'h999);
        step();
        flush = 1'b0; out_ready = 1'b0;
        set_in(1'b0, 32'd0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_pc", out_pc, 32'd0);
`ifdef FETCHQ_STATS_EN
        check("stat_flushed", stat_flushed, 32'd3);
        check("stat_pops", stat_pops, 32'd18);
        check("stat_full", stat_full_cycles, 32'd3);
`endif
        step();
        check("flush_stays_empty", 32'(count), 32'd0);

        // Reset mid-stream
        set_in(1'b1, 32'd200); step();
        set_in(1'b1, 32'd204); step();
        set_in(1'b0, 32'd0);
        check("premid_count", 32'(count), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_pc", out_pc, 32'd0);
`ifdef FETCHQ_STATS_EN
        check("midrst_stat_pops", stat_pops, 32'd0);
`endif
        set_in(1'b1, 32'd208);
        step();
        set_in(1'b0, 32'd0);
        check("post_rst_pc", out_pc, 32'd208);
        check("post_rst_count", 32'(count), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
